tuser_in_fsm: RTL and testbench

Re-attaches per-packet metadata to a packet stream on the egress side of the SDNet pipeline, undoing the split done at ingress. It accepts an AXI4-Stream packet without TUSER plus one 128-bit tuple per packet on a separate valid/ready interface. It drives an AXI4-Stream output in which every beat of packet k carries tuple k on TUSER. Tuples are buffered in a small FIFO, so the tuple may arrive before, during or after the first data beat.

---
 rtl/tuser_in_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_tuser_in_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tuser_in_fsm.sv
// Egress metadata re-attach: pairs each AXI4-Stream packet with the next tuple
// from a small FIFO and presents that tuple on TUSER for every beat of the packet.
module tuser_in_fsm #(
    parameter int DATA_WIDTH  = 256,
    parameter int KEEP_WIDTH  = 32,
    parameter int TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   tout_aclk,
    input  logic                   tout_arstn,
    input  logic                   tout_avalid,
    output logic                   tout_aready,
    input  logic [DATA_WIDTH-1:0]  tout_adata,
    input  logic [KEEP_WIDTH-1:0]  tout_akeep,
    input  logic                   tout_atlast,
    input  logic                   tout_valid,
    output logic                   tout_ready,
    input  logic [TUSER_WIDTH-1:0] tout_data,
    output logic                   tout_bvalid,
    input  logic                   tout_bready,
    output logic [DATA_WIDTH-1:0]  tout_bdata,
    output logic [KEEP_WIDTH-1:0]  tout_bkeep,
    output logic                   tout_btlast,
    output logic [TUSER_WIDTH-1:0] tout_btuser,
    output logic [0:2]             dbg_state,
    output logic [31:0]            dbg_pkt_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ZERO_C  = (AW + 1)'(0);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE = 3'b100,
        PKT  = 3'b010
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [TUSER_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW:0]            count_r;
    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;

    logic [TUSER_WIDTH-1:0] tuser_r;
    logic                   aready_s;
    logic                   a_hs_s;
    logic                   b_hs_s;

    logic                   bvalid_r;
    logic [DATA_WIDTH-1:0]  bdata_r;
    logic [KEEP_WIDTH-1:0]  bkeep_r;
    logic                   btlast_r;
    logic [TUSER_WIDTH-1:0] btuser_r;
    logic [31:0]            pkt_cnt_r;

    // ready is derived from the occupancy register only, so a pop never frees a slot in the same cycle
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == ZERO_C);
    assign push_s      = tout_valid && !full_s;
    assign tout_ready  = !full_s;

    assign a_hs_s      = tout_avalid && aready_s;
    assign b_hs_s      = bvalid_r && tout_bready;
    assign tout_aready = aready_s;

    assign tout_bvalid = bvalid_r;
    assign tout_bdata  = bdata_r;
    assign tout_bkeep  = bkeep_r;
    assign tout_btlast = btlast_r;
    assign tout_btuser = btuser_r;
    assign dbg_state   = state_r;
    assign dbg_pkt_cnt = pkt_cnt_r;

    // Tuple storage and write pointer
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {TUSER_WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= tout_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
        end
    end

    // Read pointer and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = PKT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PKT: begin
                if (a_hs_s && tout_atlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PKT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: tuple pop in IDLE, input-stream ready in PKT
    always_comb begin
        aready_s = 1'b0;
        pop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            PKT: begin
                aready_s = !bvalid_r || tout_bready;
            end
            default: begin
                aready_s = 1'b0;
                pop_s    = 1'b0;
            end
        endcase
    end

    // Tuple of the packet currently being forwarded
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            tuser_r <= {TUSER_WIDTH{1'b0}};
        end else if (pop_s) begin
            tuser_r <= mem_r[rd_ptr_r];
        end
    end

    // Single-entry output stage; a new beat overwrites one leaving in the same cycle
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            bvalid_r <= 1'b0;
            bdata_r  <= {DATA_WIDTH{1'b0}};
            bkeep_r  <= {KEEP_WIDTH{1'b0}};
            btlast_r <= 1'b0;
            btuser_r <= {TUSER_WIDTH{1'b0}};
        end else if (a_hs_s) begin
            bvalid_r <= 1'b1;
            bdata_r  <= tout_adata;
            bkeep_r  <= tout_akeep;
            btlast_r <= tout_atlast;
            btuser_r <= tuser_r;
        end else if (b_hs_s) begin
            bvalid_r <= 1'b0;
        end
    end

    // Completed-packet counter, free-running wrap
    always_ff @(posedge tout_aclk or negedge tout_arstn) begin
        if (!tout_arstn) begin
            pkt_cnt_r <= 32'd0;
        end else if (b_hs_s && btlast_r) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Scoreboard bench for tuser_in_fsm: expected beats are queued when accepted on A
// and compared in order when they leave on B.
module tb_tuser_in_fsm;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int TW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [TW-1:0] tuser;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          avalid = 1'b0;
    logic          aready;
    logic [DW-1:0] adata = '0;
    logic [KW-1:0] akeep = '0;
    logic          atlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [TW-1:0] tdata = '0;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [DW-1:0] bdata;
    logic [KW-1:0] bkeep;
    logic          btlast;
    logic [TW-1:0] btuser;
    logic [0:2]    dbg_state;
    logic [31:0]   dbg_pkt_cnt;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    beat_t prev_b;
    logic  hold_prev = 1'b0;

    tuser_in_fsm dut (
        .tout_aclk   (clk),
        .tout_arstn  (rst_n),
        .tout_avalid (avalid),
        .tout_aready (aready),
        .tout_adata  (adata),
        .tout_akeep  (akeep),
        .tout_atlast (atlast),
        .tout_valid  (tvalid),
        .tout_ready  (tready),
        .tout_data   (tdata),
        .tout_bvalid (bvalid),
        .tout_bready (bready),
        .tout_bdata  (bdata),
        .tout_bkeep  (bkeep),
        .tout_btlast (btlast),
        .tout_btuser (btuser),
        .dbg_state   (dbg_state),
        .dbg_pkt_cnt (dbg_pkt_cnt)
    );

    always #5 clk = ~clk;

    // B-side monitor: scoreboard compare on handshake, stability while stalled
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {bdata, bkeep, btlast, btuser};
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (cur !== prev_b) begin
                    errors++;
                    $display("FAIL b_stable: got data=%h tuser=%h last=%b, required data=%h tuser=%h last=%b",
                             cur.data[31:0], cur.tuser[31:0], cur.last, prev_b.data[31:0], prev_b.tuser[31:0], prev_b.last);
                end
            end
            if (bvalid && bready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: got data=%h tuser=%h, required no beat", cur.data[31:0], cur.tuser[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL b_beat: got data=%h keep=%h last=%b tuser=%h, required data=%h keep=%h last=%b tuser=%h",
                                 cur.data[31:0], cur.keep, cur.last, cur.tuser[31:0], e.data[31:0], e.keep, e.last, e.tuser[31:0]);
                    end
                end
            end
            hold_prev = bvalid && !bready;
            prev_b    = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_tuple(input logic [TW-1:0] t);
        bit ok = 1'b0;
        tvalid = 1'b1;
        tdata  = t;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: got tready=0, required 1 within 50 cycles");
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [TW-1:0] t);
        bit ok = 1'b0;
        avalid = 1'b1;
        adata  = d;
        akeep  = k;
        atlast = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (aready) begin
                exp_q.push_back({d, k, l, t});
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        avalid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got aready=0, required 1 within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL rst_tready_in: got %b, required 1", tready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({aready, bvalid, btlast} !== 3'b000) begin
            errors++; $display("FAIL rst_ctrl: got aready/bvalid/btlast=%b%b%b, required 000", aready, bvalid, btlast);
        end
        checks++;
        if (bdata !== '0 || bkeep !== '0 || btuser !== '0) begin
            errors++; $display("FAIL rst_bdata: got data=%h keep=%h tuser=%h, required 0", bdata[31:0], bkeep, btuser[31:0]);
        end
        checks++;
        if (dbg_state !== 3'b100) begin errors++; $display("FAIL rst_state: got %b, required 100", dbg_state); end
        checks++;
        if (dbg_pkt_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d, required 0", dbg_pkt_cnt); end
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b, required 1", tready); end
    endtask

    task automatic test_basic();
        bready = 1'b1;
        push_tuple(128'd44444);
        for (int i = 0; i < 3; i++) begin
            send_beat(256'd22222 + DW'(i), 32'd33333, (i == 2), 128'd44444);
        end
        wait_drain();
        checks++;
        if (dbg_pkt_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt: got %0d, required 1", dbg_pkt_cnt); end
    endtask

    task automatic test_data_first();
        avalid = 1'b1;
        adata  = 256'd777;
        akeep  = 32'h0000_00FF;
        atlast = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (aready !== 1'b0) begin errors++; $display("FAIL df_wait: got aready=%b, required 0", aready); end
        end
        tvalid = 1'b1;
        tdata  = 128'h55;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        checks++;
        if (aready !== 1'b0) begin errors++; $display("FAIL df_push_edge: got aready=%b, required 0", aready); end
        @(posedge clk);
        #1;
        checks++;
        if (aready !== 1'b1) begin errors++; $display("FAIL df_after_pop: got aready=%b, required 1", aready); end
        exp_q.push_back({256'd777, 32'h0000_00FF, 1'b1, 128'h55});
        @(posedge clk);
        #1;
        avalid = 1'b0;
        wait_drain();
        checks++;
        if (dbg_pkt_cnt !== 32'd2) begin errors++; $display("FAIL df_cnt: got %0d, required 2", dbg_pkt_cnt); end
    endtask

    task automatic test_fifo_full();
        bit seen = 1'b0;
        // first tuple goes straight to the FSM, the next four fill the FIFO
        for (int k = 1; k <= 5; k++) begin
            push_tuple(TW'(k));
        end
        checks++;
        if (tready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", tready); end
        tvalid = 1'b1;
        tdata  = 128'd6;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (tready !== 1'b0) begin errors++; $display("FAIL full_hold: got tready=%b, required 0", tready); end
        end
        send_beat(256'd101, 32'd1, 1'b1, 128'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tready) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL full_ready_return: got tready=0, required 1 after pop"); end
        for (int k = 2; k <= 6; k++) begin
            send_beat(256'd100 + DW'(k), 32'd1, 1'b1, TW'(k));
        end
        wait_drain();
        checks++;
        if (dbg_pkt_cnt !== 32'd8) begin errors++; $display("FAIL full_cnt: got %0d, required 8", dbg_pkt_cnt); end
    endtask

    task automatic test_bready_random();
        bit stop = 1'b0;
        push_tuple(128'h77);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_beat(256'd300 + DW'(i), 32'hFFFF_FFFF, (i == 3), 128'h77);
                end
                wait_drain();
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    bready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bready = 1'b1;
        checks++;
        if (dbg_pkt_cnt !== 32'd9) begin errors++; $display("FAIL rnd_cnt: got %0d, required 9", dbg_pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        bready = 1'b1;
        push_tuple(128'hA1);
        push_tuple(128'hA2);
        push_tuple(128'hA3);
        send_beat(256'd400, 32'd7, 1'b0, 128'hA1);
        send_beat(256'd401, 32'd7, 1'b0, 128'hA1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_bvalid: got %b, required 0", bvalid); end
        checks++;
        if (dbg_state !== 3'b100) begin errors++; $display("FAIL mid_state: got %b, required 100", dbg_state); end
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL mid_tready: got %b, required 1", tready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (aready !== 1'b0 || dbg_pkt_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_after: got aready=%b cnt=%0d, required 0 and 0", aready, dbg_pkt_cnt);
        end
        push_tuple(128'h99);
        send_beat(256'd500, 32'd3, 1'b1, 128'h99);
        wait_drain();
        checks++;
        if (dbg_pkt_cnt !== 32'd1) begin errors++; $display("FAIL mid_cnt: got %0d, required 1", dbg_pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_data_first();
        test_fifo_full();
        test_bready_random();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
